// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: send/busy byte handshake, FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        ipClk,
    input  logic                        ipReset,
    input  logic [7:0]                  ipTxData,
    input  logic                        ipTxSend,
    output logic                        opTxBusy,
    output logic                        opTx,
    output logic [$clog2(FIFO_DEPTH):0] opFifoCount,
    output logic                        opIdle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]    fifoMem [FIFO_DEPTH];
    logic [AW:0]   wrPtr, rdPtr;
    logic [AW:0]   count, countNext;
    logic          fifoFull, fifoEmpty;
    logic          ack, accept, pop;
    state_t        state, stateNext;
    logic [CW-1:0] bitCnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic          txNext, bitWrap;

    assign fifoEmpty   = (wrPtr == rdPtr);
    assign fifoFull    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign opTxBusy    = fifoFull | ack;
    assign accept      = ipTxSend & ~opTxBusy;
    assign bitWrap     = (bitCnt == BIT_LAST);
    assign opFifoCount = count;

    always_ff @(posedge ipClk) begin
        if (accept) begin
            fifoMem[wrPtr[AW-1:0]] <= ipTxData;
        end
    end

    // A simultaneous accept and pop cancel out, leaving the count unchanged.
    always_comb begin
        countNext = count;
        if (accept && !pop) begin
            countNext = count + PTR_ONE;
        end else if (pop && !accept) begin
            countNext = count - PTR_ONE;
        end
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            ack    <= 1'b0;
            opIdle <= 1'b1;
        end else begin
            ack    <= accept;
            count  <= countNext;
            opIdle <= (stateNext == IDLE) && (countNext == '0);
            if (accept) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
        end
    end

    // STOP chains straight into START when more bytes are waiting, so bursts have no idle gap.
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        txNext    = 1'b1;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    stateNext = START;
                end
            end
            START: begin
                txNext = 1'b0;
                if (bitWrap) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                txNext = shiftReg[bitIdx];
                if (bitWrap && (bitIdx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    stateNext = PARITY;
`else
                    stateNext = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txNext = ^shiftReg;
                if (bitWrap) begin
                    stateNext = STOP;
                end
            end
`endif
            STOP: begin
                if (bitWrap) begin
                    if (!fifoEmpty) begin
                        pop       = 1'b1;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // The line is registered, so it lags the state register by one cycle.
    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state    <= IDLE;
            opTx     <= 1'b1;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            state <= stateNext;
            opTx  <= txNext;
            if (pop) begin
                shiftReg <= fifoMem[rdPtr[AW-1:0]];
            end
            if (state == IDLE) begin
                bitCnt <= '0;
                bitIdx <= '0;
            end else begin
                bitCnt <= bitWrap ? '0 : bitCnt + CNT_ONE;
                if ((state == DATA) && bitWrap) begin
                    bitIdx <= bitIdx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, serial-line decoder and byte scoreboard.
module tb_uart_tx_fifo;
    localparam int DIV   = 4;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic          ipClk = 1'b0;
    logic          ipReset;
    logic [7:0]    ipTxData;
    logic          ipTxSend;
    logic          opTxBusy;
    logic          opTx;
    logic [CW-1:0] opFifoCount;
    logic          opIdle;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0]  sbQ[$];
    int          acceptCount = 0;
    int          framesRx    = 0;
    logic [7:0]  lastRxData  = '0;
    logic        lastRxParity = 1'b0;
    logic [10:0] rxBits      = '1;
    bit          monInFrame  = 1'b0;
    int          monCyc      = 0;
    bit          checkGap    = 1'b0;
    bit          gapPending  = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       parity;
    } vec_t;
    vec_t vecs[6];

    uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .ipTxData   (ipTxData),
        .ipTxSend   (ipTxSend),
        .opTxBusy   (opTxBusy),
        .opTx       (opTx),
        .opFifoCount(opFifoCount),
        .opIdle     (opIdle)
    );

    always #5 ipClk = ~ipClk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] d);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Predicts accepts from the pre-edge handshake and decodes frames off the line.
    always @(negedge ipClk) begin
        if (ipReset) begin
            monInFrame = 1'b0;
            gapPending = 1'b0;
            sbQ.delete();
        end else begin
            if (ipTxSend && !opTxBusy) begin
                sbQ.push_back(ipTxData);
                acceptCount++;
            end
            if (monInFrame) begin
                monCyc++;
                if ((monCyc % DIV) == (DIV / 2)) begin
                    rxBits[monCyc / DIV] = opTx;
                end
                if (monCyc == FRAME * DIV - 1) begin
                    framesRx++;
                    lastRxData   = rxBits[8:1];
                    lastRxParity = rxBits[9];
                    if (sbQ.size() == 0) begin
                        assertCount++;
                        failCount++;
                        $display("[TB] FAIL unexpectedFrame: actual frame bits %b, required no frame", rxBits);
                    end else begin
                        checkOutput("frame", 32'(rxBits), 32'(makeFrame(sbQ.pop_front())));
                    end
                    gapPending = checkGap && (sbQ.size() != 0);
                    monInFrame = 1'b0;
                end
            end else begin
                if (gapPending) begin
                    gapPending = 1'b0;
                    checkOutput("backToBackStart", 32'(opTx), 32'(0));
                end
                if (opTx == 1'b0) begin
                    monInFrame = 1'b1;
                    monCyc     = 0;
                    rxBits     = '1;
                end
            end
        end
    end

    task automatic waitNeg();
        @(negedge ipClk);
        #1;
    endtask

    // Master that raises send and holds it until it sees busy.
    task automatic applyStimulus(input logic [7:0] d, output int sawBusy, output int peakCount);
        sawBusy   = 0;
        peakCount = 0;
        @(posedge ipClk);
        #1;
        ipTxData = d;
        ipTxSend = 1'b1;
        for (int k = 0; k < 20 && sawBusy == 0; k++) begin
            waitNeg();
            if (int'(opFifoCount) > peakCount) peakCount = int'(opFifoCount);
            if (opTxBusy) sawBusy = 1;
        end
        ipTxSend = 1'b0;
        if (sawBusy == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL busyWait: actual busy never seen, required busy within 20 cycles");
        end
    endtask

    task automatic waitIdle(input int maxCycles);
        for (int k = 0; k < maxCycles && !opIdle; k++) waitNeg();
        if (!opIdle) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL idleWait: actual opIdle 0, required 1 within %0d cycles", maxCycles);
        end
    endtask

    task automatic waitMon(input int cyc, input int maxCycles);
        for (int k = 0; k < maxCycles && !(monInFrame && monCyc == cyc); k++) waitNeg();
        if (!(monInFrame && monCyc == cyc)) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL frameWait: actual frame position not reached, required cycle %0d", cyc);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int saw, peak, lat, startFrames, startAcc, busyTotal;
        int offered, heldFull, busyHeld;

        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'h80, 1'b1};
        vecs[4] = '{8'hFF, 1'b0};
        vecs[5] = '{8'h01, 1'b1};

        ipReset  = 1'b1;
        ipTxSend = 1'b0;
        ipTxData = '0;
        waitNeg();
        checkOutput("resetTx", 32'(opTx), 32'(1));
        checkOutput("resetBusy", 32'(opTxBusy), 32'(0));
        checkOutput("resetCount", 32'(opFifoCount), 32'(0));
        checkOutput("resetIdle", 32'(opIdle), 32'(1));
        @(posedge ipClk);
        #1;
        ipReset = 1'b0;
        repeat (2) waitNeg();

        // Single frames from the table: latency, frame length, decoded data and parity.
        foreach (vecs[i]) begin
            startFrames = framesRx;
            applyStimulus(vecs[i].data, saw, peak);
            checkOutput("idleDropsOnAccept", 32'(opIdle), 32'(0));
            lat = 0;
            for (int k = 0; k < 20 && opTx; k++) begin
                waitNeg();
                lat++;
            end
            checkOutput("startLatency", 32'(lat), 32'(2));
            for (int k = 0; k < 200 && !opIdle; k++) begin
                waitNeg();
                lat++;
            end
            checkOutput("idleAfterFrame", 32'(lat), 32'(1 + FRAME * DIV));
            repeat (2) waitNeg();
            checkOutput("frameCount", 32'(framesRx - startFrames), 32'(1));
            checkOutput("rxData", 32'(lastRxData), 32'(vecs[i].data));
`ifdef UART_TX_PARITY_EN
            checkOutput("rxParity", 32'(lastRxParity), 32'(vecs[i].parity));
`endif
        end

        // Hold-until-busy master writes exactly once.
        startAcc = acceptCount;
        applyStimulus(8'h41, saw, peak);
        busyTotal = saw;
        for (int k = 0; k < 6; k++) begin
            waitNeg();
            if (opTxBusy) busyTotal++;
            if (int'(opFifoCount) > peak) peak = int'(opFifoCount);
        end
        checkOutput("handshakeWrites", 32'(acceptCount - startAcc), 32'(1));
        checkOutput("handshakeBusyCycles", 32'(busyTotal), 32'(1));
        checkOutput("handshakePeakCount", 32'(peak), 32'(1));
        waitIdle(200);
        repeat (2) waitNeg();

        // Burst of 18 offers at the maximum rate; the last must be refused while full.
        checkGap    = 1'b1;
        startAcc    = acceptCount;
        startFrames = framesRx;
        offered     = 0;
        heldFull    = 0;
        busyHeld    = 1;
        for (int c = 0; c < 200; c++) begin
            @(posedge ipClk);
            #1;
            ipTxData = 8'(8'h10 + offered);
            ipTxSend = 1'b1;
            waitNeg();
            if (offered < 17) begin
                if (!opTxBusy) offered++;
            end else begin
                heldFull++;
                if (!opTxBusy) busyHeld = 0;
                if (heldFull == 6) break;
            end
        end
        ipTxSend = 1'b0;
        checkOutput("burstAccepted", 32'(acceptCount - startAcc), 32'(17));
        checkOutput("busyHeldWhileFull", 32'(busyHeld), 32'(1));
        checkOutput("burstCountFull", 32'(opFifoCount), 32'(16));
        waitIdle(17 * FRAME * DIV + 100);
        repeat (2) waitNeg();
        checkOutput("burstFrames", 32'(framesRx - startFrames), 32'(17));
        checkGap = 1'b0;

        // Reset in the middle of a data bit with three bytes still queued.
        applyStimulus(8'hA5, saw, peak);
        applyStimulus(8'h11, saw, peak);
        applyStimulus(8'h22, saw, peak);
        applyStimulus(8'h33, saw, peak);
        waitMon(2 * DIV + 1, 100);
        checkOutput("preResetCount", 32'(opFifoCount), 32'(3));
        checkOutput("preResetLine", 32'(opTx), 32'(0));
        ipReset = 1'b1;
        #1;
        checkOutput("asyncResetTx", 32'(opTx), 32'(1));
        checkOutput("asyncResetCount", 32'(opFifoCount), 32'(0));
        checkOutput("asyncResetIdle", 32'(opIdle), 32'(1));
        checkOutput("asyncResetBusy", 32'(opTxBusy), 32'(0));
        waitNeg();
        ipReset = 1'b0;
        startFrames = framesRx;
        repeat (3) waitNeg();
        checkOutput("postResetLine", 32'(opTx), 32'(1));
        applyStimulus(8'h3C, saw, peak);
        waitIdle(200);
        repeat (2) waitNeg();
        checkOutput("postResetFrames", 32'(framesRx - startFrames), 32'(1));
        checkOutput("postResetData", 32'(lastRxData), 32'(8'h3C));

        // Accept during the stop bit: next start follows the stop bit with no gap.
        checkGap    = 1'b1;
        startFrames = framesRx;
        applyStimulus(8'h5A, saw, peak);
        waitMon((FRAME - 1) * DIV - 1, 100);
        applyStimulus(8'hC3, saw, peak);
        checkOutput("stopAcceptCount", 32'(opFifoCount), 32'(1));
        waitMon(0, 20);
        checkOutput("stopCountBack", 32'(opFifoCount), 32'(0));
        waitIdle(200);
        repeat (2) waitNeg();
        checkOutput("stopFrames", 32'(framesRx - startFrames), 32'(2));
        checkOutput("stopLastData", 32'(lastRxData), 32'(8'hC3));
        checkGap = 1'b0;

        checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
